// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM state
// type and the default toggle-register address.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      READ = 1'b1
   } dmem_state_e;

   localparam logic [31:0] DEFAULT_TOGGLE_ADDR = 32'd52;

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM: synchronous read with one cycle of latency and
// per-byte write enables. Contents are never reset.
module dmem_ram #(
   parameter int DEPTH_WORDS = 1024,
   localparam int AW = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          en,
   input  logic [3:0]    we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (en) begin
         for (int i = 0; i < 4; i++) begin
            if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// MEMORY-stage load/store target: zero-wait stores and errors, one-wait loads.
// Optional LED toggle register enabled by `define DMEM_MMIO_TOGGLE_EN.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] TOGGLE_ADDR = DEFAULT_TOGGLE_ADDR
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        stall,
   output logic [31:0] toggle_value
);

   localparam int AW = $clog2(DEPTH_WORDS);

   function automatic logic [31:0] extend_load(input logic [2:0]  f3,
                                               input logic [1:0]  lane,
                                               input logic [31:0] word);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      b = word[8*lane +: 8];
      h = lane[1] ? word[31:16] : word[15:0];
      case (f3)
         F3_B:    return {{24{b[7]}}, b};
         F3_H:    return {{16{h[15]}}, h};
         F3_BU:   return {24'd0, b};
         F3_HU:   return {16'd0, h};
         default: return word;
      endcase
   endfunction

   dmem_state_e   state;
   logic [AW-1:0] word_idx;
   logic          toggle_hit, is_tog;
   logic          bad, idle_req, store_go, load_go, in_read;
   logic [3:0]    be;
   logic [31:0]   lane_wdata, ram_rdata, rd_word, toggle_r;
   logic [2:0]    funct3_p1;
   logic [1:0]    lane_p1;
   logic          tog_p1;
   logic          unused_addr_hi;

   assign word_idx       = req_addr[AW+1:2];
   assign unused_addr_hi = ^req_addr[31:AW+2];
   assign toggle_hit     = (word_idx == TOGGLE_ADDR[AW+1:2]);

   always_comb begin
      bad = 1'b0;
      case (req_funct3)
         F3_B:    bad = 1'b0;
         F3_H:    bad = req_addr[0];
         F3_W:    bad = |req_addr[1:0];
         F3_BU:   bad = req_write;
         F3_HU:   bad = req_write | req_addr[0];
         default: bad = 1'b1;
      endcase
   end

   assign idle_req = resetn & (state == IDLE) & req_valid;
   assign store_go = idle_req & ~bad & req_write;
   assign load_go  = idle_req & ~bad & ~req_write;
   assign in_read  = resetn & (state == READ);

   // Stores are replicated across lanes; the enables pick the target bytes.
   always_comb begin
      be         = 4'b1111;
      lane_wdata = req_wdata;
      case (req_funct3)
         F3_B: begin
            be         = 4'b0001 << req_addr[1:0];
            lane_wdata = {4{req_wdata[7:0]}};
         end
         F3_H: begin
            be         = req_addr[1] ? 4'b1100 : 4'b0011;
            lane_wdata = {2{req_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
      .clk   (clk),
      .en    ((store_go | load_go) & ~is_tog),
      .we    (be & {4{store_go & ~is_tog}}),
      .addr  (word_idx),
      .wdata (lane_wdata),
      .rdata (ram_rdata)
   );

`ifdef DMEM_MMIO_TOGGLE_EN
   assign is_tog = toggle_hit;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         toggle_r <= '0;
      end else if (store_go && is_tog) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) toggle_r[8*i +: 8] <= lane_wdata[8*i +: 8];
         end
      end
   end
`else
   logic unused_toggle_hit;
   assign unused_toggle_hit = toggle_hit;
   assign is_tog            = 1'b0;
   assign toggle_r          = '0;
`endif

   assign toggle_value = toggle_r;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE:    state <= load_go ? READ : IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Stage p1: load attributes held for the READ cycle
   always_ff @(posedge clk) begin
      if (load_go) begin
         funct3_p1 <= req_funct3;
         lane_p1   <= req_addr[1:0];
         tog_p1    <= is_tog;
      end
   end

   assign rd_word   = tog_p1 ? toggle_r : ram_rdata;
   assign req_ready = in_read | (idle_req & (bad | req_write));
   assign rsp_err   = idle_req & bad;
   assign rsp_rdata = in_read ? extend_load(funct3_p1, lane_p1, rd_word) : '0;
   assign stall     = resetn & req_valid & ~req_ready;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized
// traffic against a byte-addressed reference model.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        resetn;
   logic        req_valid, req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        req_ready, rsp_err, stall;
   logic [31:0] rsp_rdata, toggle_value;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] mem_m [64];
   logic [7:0] tog_m [4];

   always #5 clk = ~clk;

   dmem_responder dut (
      .clk          (clk),
      .resetn       (resetn),
      .req_valid    (req_valid),
      .req_write    (req_write),
      .req_funct3   (req_funct3),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_ready    (req_ready),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .stall        (stall),
      .toggle_value (toggle_value)
   );

   // Issue one request and wait (bounded) for its ready pulse.
   task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd,
                         output logic er, output int lat, output int stalls);
      @(negedge clk);
      req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
      lat = 0; stalls = 0; rd = '0; er = 1'b0;
      while (1) begin
         #1;
         if (req_ready) begin
            rd = rsp_rdata; er = rsp_err;
            break;
         end
         if (stall) stalls++;
         lat++;
         if (lat > 5) break;
         @(negedge clk);
      end
      @(posedge clk);
   endtask

   task automatic go_idle();
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   function automatic bit model_is_tog(input logic [31:0] a);
`ifdef DMEM_MMIO_TOGGLE_EN
      return a[11:2] == 10'd13;
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit model_err(input logic w, input logic [2:0] f3, input logic [31:0] a);
      if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
      if (f3 == 2 && (a % 4) != 0) return 1'b1;
      if ((f3 == 1 || f3 == 5) && (a % 2) != 0) return 1'b1;
      if (w && (f3 == 4 || f3 == 5)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int model_size(input logic [2:0] f3);
      if (f3 == 0 || f3 == 4) return 1;
      if (f3 == 1 || f3 == 5) return 2;
      return 4;
   endfunction

   task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
      int base;
      base = int'(a[5:0]);
      for (int k = 0; k < model_size(f3); k++) begin
         if (model_is_tog(a)) tog_m[(base + k) % 4] = wd[8*k +: 8];
         else                 mem_m[base + k]      = wd[8*k +: 8];
      end
   endtask

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
      int base;
      int n;
      longint unsigned v;
      base = int'(a[5:0]);
      n = model_size(f3);
      v = 0;
      for (int k = n - 1; k >= 0; k--) begin
         v = v * 256;
         if (model_is_tog(a)) v = v + longint'(tog_m[(base + k) % 4]);
         else                 v = v + longint'(mem_m[base + k]);
      end
      if (f3 == 0 && v >= 128)   v = v + 64'hFFFF_FF00;
      if (f3 == 1 && v >= 32768) v = v + 64'hFFFF_0000;
      return v[31:0];
   endfunction

   task automatic test_reset();
      resetn = 1'b0;
      req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10; req_wdata = '0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({req_ready, rsp_err, stall} !== 3'b000)
         $display("FAIL reset_ctrl ready/err/stall got %b required 000", {req_ready, rsp_err, stall});
      else n_pass++;
      n_checks++;
      if (rsp_rdata !== 32'h0) $display("FAIL reset_rdata got %h required 0", rsp_rdata);
      else n_pass++;
      n_checks++;
      if (toggle_value !== 32'h0) $display("FAIL reset_toggle got %h required 0", toggle_value);
      else n_pass++;
      req_valid = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      for (int i = 0; i < 4; i++) tog_m[i] = 8'h0;
   endtask

   task automatic test_directed();
      logic [31:0] rd; logic er; int lat, st;
      logic [2:0]  f3s [9]  = '{3'd2, 3'd0, 3'd4, 3'd2, 3'd1, 3'd5, 3'd1, 3'd2, 3'd2};
      logic        ws  [9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [31:0] as  [9]  = '{32'h10, 32'h13, 32'h13, 32'h10, 32'h12, 32'h12, 32'h10, 32'h10, 32'h10};
      logic [31:0] wds [9]  = '{32'hDEADBEEF, 32'h123456AA, 0, 0, 0, 0, 32'h7FFF, 0, 0};
      logic [31:0] exp [9]  = '{0, 0, 32'h000000AA, 32'hAAADBEEF, 32'hFFFFAAAD, 32'h0000AAAD,
                                0, 32'hAAAD7FFF, 32'hAAAD7FFF};
      do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, rd, er, lat, st);
      n_checks++;
      if (lat !== 0) $display("FAIL sw_latency got %0d required 0", lat); else n_pass++;
      do_req(1'b0, 3'd2, 32'h10, 0, rd, er, lat, st);
      n_checks++;
      if (lat !== 1 || st !== 1) $display("FAIL lw_latency got lat %0d stall %0d required 1 1", lat, st);
      else n_pass++;
      n_checks++;
      if (rd !== 32'hDEADBEEF) $display("FAIL lw_first got %h required deadbeef", rd); else n_pass++;
      do_req(1'b1, 3'd0, 32'h13, 32'h123456AA, rd, er, lat, st);
      do_req(1'b0, 3'd0, 32'h13, 0, rd, er, lat, st);
      n_checks++;
      if (rd !== 32'hFFFFFFAA) $display("FAIL lb_sign got %h required ffffffaa", rd); else n_pass++;
      for (int i = 2; i < 9; i++) begin
         do_req(ws[i], f3s[i], as[i], wds[i], rd, er, lat, st);
         if (!ws[i]) begin
            n_checks++;
            if (rd !== exp[i] || er !== 1'b0)
               $display("FAIL directed_%0d got %h err %b required %h err 0", i, rd, er, exp[i]);
            else n_pass++;
         end
      end
      go_idle();
   endtask

   task automatic test_errors();
      logic [31:0] rd; logic er; int lat, st;
      logic        ws [3] = '{1'b0, 1'b1, 1'b0};
      logic [2:0]  fs [3] = '{3'd2, 3'd1, 3'd3};
      logic [31:0] as [3] = '{32'h11, 32'h13, 32'h10};
      for (int i = 0; i < 3; i++) begin
         do_req(ws[i], fs[i], as[i], 32'hFFFF_FFFF, rd, er, lat, st);
         n_checks++;
         if (er !== 1'b1 || lat !== 0 || rd !== 32'h0)
            $display("FAIL err_%0d got err %b lat %0d rdata %h required 1 0 0", i, er, lat, rd);
         else n_pass++;
      end
      do_req(1'b0, 3'd2, 32'h10, 0, rd, er, lat, st);
      n_checks++;
      if (rd !== 32'hAAAD7FFF) $display("FAIL after_err got %h required aaad7fff", rd); else n_pass++;
      go_idle();
   endtask

   task automatic test_mmio();
      logic [31:0] rd; logic er; int lat, st;
      do_req(1'b1, 3'd2, 32'h34, 32'h1, rd, er, lat, st);
      go_idle();
      #1;
      n_checks++;
`ifdef DMEM_MMIO_TOGGLE_EN
      if (toggle_value !== 32'h1) $display("FAIL toggle_set got %h required 1", toggle_value);
      else n_pass++;
      tog_m[0] = 8'h1;
`else
      if (toggle_value !== 32'h0) $display("FAIL toggle_off got %h required 0", toggle_value);
      else n_pass++;
`endif
      do_req(1'b0, 3'd2, 32'h34, 0, rd, er, lat, st);
      n_checks++;
      if (rd !== 32'h1) $display("FAIL lw_toggle got %h required 1", rd); else n_pass++;
      go_idle();
   endtask

   task automatic test_reset_in_read();
      logic [31:0] rd; logic er; int lat, st;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10;
      @(posedge clk);
      #2 resetn = 1'b0;
      #1;
      n_checks++;
      if (req_ready !== 1'b0 || stall !== 1'b0 || rsp_rdata !== 32'h0)
         $display("FAIL reset_in_read got ready %b stall %b rdata %h required 0 0 0",
                  req_ready, stall, rsp_rdata);
      else n_pass++;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      for (int i = 0; i < 4; i++) tog_m[i] = 8'h0;
      do_req(1'b0, 3'd2, 32'h10, 0, rd, er, lat, st);
      n_checks++;
      if (rd !== 32'hAAAD7FFF || lat !== 1)
         $display("FAIL reload got %h lat %0d required aaad7fff 1", rd, lat);
      else n_pass++;
      n_checks++;
      if (toggle_value !== 32'h0) $display("FAIL toggle_after_reset got %h required 0", toggle_value);
      else n_pass++;
      go_idle();
   endtask

   task automatic test_random();
      logic [31:0] rd, a, wd; logic er, w; logic [2:0] f3; int lat, st;
      bit exp_err;
      for (int i = 0; i < 16; i++) begin
         wd = $urandom;
         do_req(1'b1, 3'd2, 32'(i * 4), wd, rd, er, lat, st);
         model_store(3'd2, 32'(i * 4), wd);
      end
      for (int n = 0; n < 300; n++) begin
         w  = 1'($urandom_range(0, 1));
         f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) :
              ($urandom_range(0, 2) == 0 ? 3'd2 : 3'($urandom_range(0, 5)));
         a  = {18'($urandom), 8'd0, 6'($urandom)};
         a[11:6] = '0;
         if ($urandom_range(0, 3) != 0) begin
            if (f3 == 2) a[1:0] = 2'b00;
            if (f3 == 1 || f3 == 5) a[0] = 1'b0;
         end
         wd = $urandom;
         exp_err = model_err(w, f3, a);
         do_req(w, f3, a, wd, rd, er, lat, st);
         n_checks++;
         if (exp_err) begin
            if (er !== 1'b1 || lat !== 0)
               $display("FAIL rand_err_%0d got err %b lat %0d required 1 0", n, er, lat);
            else n_pass++;
         end else if (w) begin
            model_store(f3, a, wd);
            if (er !== 1'b0 || lat !== 0)
               $display("FAIL rand_st_%0d got err %b lat %0d required 0 0", n, er, lat);
            else n_pass++;
         end else begin
            if (er !== 1'b0 || lat !== 1 || st !== 1 || rd !== model_load(f3, a))
               $display("FAIL rand_ld_%0d f3 %0d addr %h got %h lat %0d required %h lat 1",
                        n, f3, a, rd, lat, model_load(f3, a));
            else n_pass++;
         end
         if ($urandom_range(0, 3) == 0) go_idle();
      end
      go_idle();
      #1;
      n_checks++;
      if (toggle_value !== {tog_m[3], tog_m[2], tog_m[1], tog_m[0]})
         $display("FAIL rand_toggle got %h required %h", toggle_value,
                  {tog_m[3], tog_m[2], tog_m[1], tog_m[0]});
      else n_pass++;
   endtask

   initial begin
      req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
      test_reset();
      test_directed();
      test_errors();
      test_mmio();
      test_reset_in_read();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined RISC-V core: it is the target side of the MEMORY-stage load/store port. It accepts one request at a time, performs byte, halfword or word stores and loads with RISC-V sign/zero extension against a single-port word RAM, and signals completion with a ready handshake. It exposes a stall to the hazard unit and, optionally, a memory-mapped LED toggle register.

## Interface
- `DEPTH_WORDS`, default 1024: RAM size in 32-bit words; power of two.
- `TOGGLE_ADDR`, default 32'd52: byte address of the toggle register.
- `clk` in 1: single clock; all state updates on the rising edge.
- `resetn` in 1: reset, asynchronous and active-low.
- `req_valid` in 1: a request is present; held stable until `req_ready`.
- `req_write` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RISC-V funct3 (0 lb/sb, 1 lh/sh, 2 lw/sw, 4 lbu, 5 lhu).
- `req_addr` in 32: byte address (ALUResultM).
- `req_wdata` in 32: store data (WriteDataM), right-aligned.
- `req_ready` out 1: one-cycle completion pulse.
- `rsp_rdata` out 32: extended load data; valid only while `req_ready`=1 for a load.
- `rsp_err` out 1: misaligned or illegal funct3; valid only with `req_ready`.
- `stall` out 1: `req_valid & ~req_ready`, to the pipeline's StallF/StallD logic.
- `toggle_value` out 32: LED toggle register.

## Operation
- FSM states: IDLE, READ.
- IDLE + `req_valid` + error condition: `req_ready`=1 and `rsp_err`=1 this cycle, `rsp_rdata`=0, no RAM or register change; stay IDLE.
- Error condition: funct3 in {3,6,7}; word access with addr[1:0]≠0; halfword with addr[0]≠0; store with funct3 4 or 5.
- IDLE + valid store: `req_ready`=1 combinationally; byte enables written at this edge; stay IDLE.
- sb: wdata[7:0] written to lane addr[1:0]; sh: wdata[15:0] to lanes {addr[1],0} and {addr[1],1}; sw: all four lanes.
- IDLE + valid load: RAM read issued at this edge; go to READ.
- READ: `req_ready`=1; `rsp_rdata` = selected lane(s) of RAM output, sign-extended (lb, lh) or zero-extended (lbu, lhu); return to IDLE.
- Word index = addr[log2(DEPTH_WORDS)+1:2]; higher address bits ignored (aliasing, no error).
- Outputs are undefined except as listed; `rsp_rdata` and `rsp_err` are driven to 0 whenever `req_ready`=0.

## Timing
- Store and error latency: 0 wait states; ready in the acceptance cycle.
- Load latency: 1 wait state; ready in the cycle after acceptance, and `stall`=1 for exactly one cycle.
- Back-to-back: a new request may be accepted in the cycle after any `req_ready`.
- Reset (asynchronous): state goes to IDLE and `toggle_value` is cleared to 0. While `resetn`=0, `req_ready`, `rsp_err`, `stall` and `rsp_rdata` are forced to 0.
- Reset during READ: the load is abandoned and no response is produced; the requester reissues it.
- RAM contents are not cleared by reset.

## Configuration
- `DMEM_MMIO_TOGGLE_EN` defined: accesses with word index equal to TOGGLE_ADDR>>2 target `toggle_value` instead of RAM.
  - Stores to it update only the enabled lanes.
  - Loads from it return `toggle_value` in READ with normal extension.
  - The RAM word at that index is never written.
- Macro undefined: `toggle_value` is tied to 0, and TOGGLE_ADDR is ordinary RAM.

## Structure
- Package `dmem_pkg` holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the state enum (IDLE, READ);
  - the default TOGGLE_ADDR.
- Sub-module `dmem_ram`: single-port, synchronous-read word RAM with a 4-bit byte-write enable and 1-cycle read latency, sized by DEPTH_WORDS. Lane extraction, extension and the FSM stay in the top level.

## Test plan
- sw 0x10 data 0xDEADBEEF: `req_ready` in the same cycle. Then lw 0x10: `stall` for 1 cycle, and in the next cycle `req_ready`=1 with `rsp_rdata`=0xDEADBEEF.
- sb 0x13 data 0x123456AA: lb 0x13 returns 0xFFFFFFAA; lbu 0x13 returns 0x000000AA; lw 0x10 returns 0xAAADBEEF.
- lh 0x12 returns 0xFFFFAAAD; lhu 0x12 returns 0x0000AAAD. sh 0x10 data 0x7FFF, then lw 0x10 returns 0xAAAD7FFF.
- lw 0x11, sh 0x13 and funct3=3 each give `req_ready`=1 and `rsp_err`=1 with no wait state; a following lw 0x10 still returns 0xAAAD7FFF.
- sw 0x34 data 0x1:
  - with `DMEM_MMIO_TOGGLE_EN`: `toggle_value`=1, lw 0x34 returns 1, and RAM word 13 is unchanged;
  - without the macro: `toggle_value`=0 and lw 0x34 returns 1.
- Assert `resetn`=0 during READ of lw 0x10: `req_ready`=0 and `stall`=0 immediately. After release, lw 0x10 returns 0xAAAD7FFF and `toggle_value`=0.
